wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of non-frozen cycles a buffered unit result may wait before forced grant (range 1..15).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port freeze  in  1  pipeline freeze (dbg, mem_hold or f_stall); holds all state.
REQ-005 SHALL have port pipe_valid  in  1  in-order MEM/WB result (ALU, memory or CSR) present.
REQ-006 SHALL have port pipe_rd  in  5  destination register of the pipe result.
REQ-007 SHALL have port pipe_data  in  32  pipe result value.
REQ-008 SHALL have port pipe_fpusrc  in  1  pipe result targets the FP register file.
REQ-009 SHALL have ports {mul,div}_valid  in  1  multiplier/divider result offered.
REQ-010 SHALL have ports {mul,div}_ready  out  1  unit buffer can accept a result.
REQ-011 SHALL have ports {mul,div}_rd  in  5, {mul,div}_data  in  32, {mul,div}_fpusrc  in  1  unit result fields.
REQ-012 SHALL have port wb_valid  out  1  register-file write enable for the shared write port.
REQ-013 SHALL have ports wb_rd  out  5, wb_data  out  32, wb_fpusrc  out  1  write-port fields.
REQ-014 SHALL have port pipe_stall  out  1  pipe result not consumed this cycle; upstream holds it.

Function
REQ-015 SHALL hold one single-entry buffer per unit (mul, div): full flag, rd, data, fpusrc, 4-bit wait counter.
REQ-016 SHALL drive x_ready = !x_full && !freeze, from registered state only; a buffer emptied by grant becomes ready the next cycle.
REQ-017 SHALL capture a unit result on x_valid && x_ready, setting x_full on the next edge.
REQ-018 SHALL, each non-frozen cycle, choose one grant: forced (a full buffer whose wait == STARVE_LIMIT; mul before div on tie), else pipe if pipe_valid, else mul if full, else div if full, else none.
REQ-019 SHALL register the granted fields onto wb_* on the next edge (latency one cycle), with wb_valid=1 when there is a grant; wb_valid=0 when there is none.
REQ-020 SHALL force wb_valid=0 for a granted entry with rd==0 and fpusrc==0 (x0 write dropped), while still consuming the entry.
REQ-021 SHALL clear x_full and wait on grant; otherwise, when full, increment wait per non-frozen cycle, saturating at STARVE_LIMIT.
REQ-022 SHALL drive pipe_stall = !freeze && pipe_valid && (forced grant active), combinationally; pipe_stall=0 otherwise.
REQ-023 SHALL, while freeze=1, hold buffers, counters and wb_* unchanged, with {mul,div}_ready=0 and pipe_stall=0.
REQ-024 SHALL never grant more than one source per cycle, and never drop or duplicate a buffered result.
REQ-025 SHALL keep wb_data, wb_rd and wb_fpusrc unchanged when wb_valid returns to 0.

Reset
REQ-026 SHALL, on Rst low (any time, asynchronously), clear every buffer, wait counter and wb_* output to 0, with pipe_stall=0 and {mul,div}_ready=0 while low.
REQ-027 SHALL discard in-flight buffered results on reset mid-operation; on the first edge after Rst rises, ready=1.

Verification
REQ-028 Pipe-only: pipe_valid=1, rd=5, data=0xDEADBEEF for 1 cycle -> next cycle wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF; then wb_valid=0.
REQ-029 Contention: mul result rd=3 is buffered while pipe_valid=1 continuously with STARVE_LIMIT=4 -> the pipe is granted for 4 cycles, then a forced mul grant with pipe_stall=1 for one cycle; wb_rd=3 follows one cycle later.
REQ-030 Simultaneous: mul and div both full at equal wait, pipe idle -> mul is written first, div next cycle; div_ready=0 until the cycle after its grant.
REQ-031 Freeze: assert freeze for 3 cycles with mul full -> wb_* held, mul_ready=0, wait counter unchanged; granting resumes after release.
REQ-032 x0/reset: pipe rd=0, fpusrc=0 -> wb_valid stays 0; pull Rst low mid-cycle with both buffers full -> outputs 0 immediately, and buffers are empty after release.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Shared register-file write-port arbiter. The in-order MEM/WB
//               pipe result competes with the out-of-order multiplier and
//               divider results. Each unit owns a single-entry buffer with a
//               wait counter; a buffer that has waited STARVE_LIMIT unfrozen
//               cycles is force-granted, stalling the pipe for that cycle.
//               The granted write reaches wb_* one cycle later.
// Ports       : clk, Rst (async, active-low)     - clock / reset
//               freeze                           - hold all state
//               pipe_valid/rd/data/fpusrc        - in-order pipe result
//               pipe_stall                       - pipe result not consumed
//               {mul,div}_valid/rd/data/fpusrc   - unit result offer
//               {mul,div}_ready                  - unit buffer can accept
//               wb_valid/rd/data/fpusrc          - registered write port
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        freeze,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        pipe_fpusrc,
  input  logic        mul_valid,
  output logic        mul_ready,
  input  logic [4:0]  mul_rd,
  input  logic [31:0] mul_data,
  input  logic        mul_fpusrc,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic [4:0]  div_rd,
  input  logic [31:0] div_data,
  input  logic        div_fpusrc,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_fpusrc,
  output logic        pipe_stall
);

  localparam logic [3:0] C_LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [1:0] C_SEL_NONE = 2'd0;
  localparam logic [1:0] C_SEL_PIPE = 2'd1;
  localparam logic [1:0] C_SEL_MUL  = 2'd2;
  localparam logic [1:0] C_SEL_DIV  = 2'd3;

  // Unit buffers
  logic        r_mul_full;
  logic [4:0]  r_mul_rd;
  logic [31:0] r_mul_data;
  logic        r_mul_fpusrc;
  logic [3:0]  r_mul_wait;
  logic        r_div_full;
  logic [4:0]  r_div_rd;
  logic [31:0] r_div_data;
  logic        r_div_fpusrc;
  logic [3:0]  r_div_wait;

  logic        w_mul_force;
  logic        w_div_force;
  logic        w_force;
  logic [1:0]  w_sel;
  logic [4:0]  w_gnt_rd;
  logic [31:0] w_gnt_data;
  logic        w_gnt_fpusrc;
  logic        w_wr_en;

  assign w_mul_force = r_mul_full && (r_mul_wait == C_LIMIT);
  assign w_div_force = r_div_full && (r_div_wait == C_LIMIT);
  assign w_force     = w_mul_force || w_div_force;

  // Ready depends only on buffer state, freeze and reset, never on the
  // current grant, so a buffer drained by a grant accepts one cycle later.
  assign mul_ready  = Rst && !r_mul_full && !freeze;
  assign div_ready  = Rst && !r_div_full && !freeze;
  assign pipe_stall = !freeze && pipe_valid && w_force;

  // Grant priority: starved buffer (mul first), pipe, mul, div.
  always_comb begin
    w_sel        = C_SEL_NONE;
    w_gnt_rd     = 5'd0;
    w_gnt_data   = 32'd0;
    w_gnt_fpusrc = 1'b0;
    if (w_mul_force) begin
      w_sel = C_SEL_MUL;
    end else if (w_div_force) begin
      w_sel = C_SEL_DIV;
    end else if (pipe_valid) begin
      w_sel = C_SEL_PIPE;
    end else if (r_mul_full) begin
      w_sel = C_SEL_MUL;
    end else if (r_div_full) begin
      w_sel = C_SEL_DIV;
    end
    case (w_sel)
      C_SEL_PIPE: begin
        w_gnt_rd     = pipe_rd;
        w_gnt_data   = pipe_data;
        w_gnt_fpusrc = pipe_fpusrc;
      end
      C_SEL_MUL: begin
        w_gnt_rd     = r_mul_rd;
        w_gnt_data   = r_mul_data;
        w_gnt_fpusrc = r_mul_fpusrc;
      end
      C_SEL_DIV: begin
        w_gnt_rd     = r_div_rd;
        w_gnt_data   = r_div_data;
        w_gnt_fpusrc = r_div_fpusrc;
      end
      default: begin
        w_gnt_rd     = 5'd0;
        w_gnt_data   = 32'd0;
        w_gnt_fpusrc = 1'b0;
      end
    endcase
  end

  // Integer x0 writes are consumed but never reach the register file.
  assign w_wr_en = (w_sel != C_SEL_NONE) && ((w_gnt_rd != 5'd0) || w_gnt_fpusrc);

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_mul_full   <= 1'b0;
      r_mul_rd     <= 5'd0;
      r_mul_data   <= 32'd0;
      r_mul_fpusrc <= 1'b0;
      r_mul_wait   <= 4'd0;
    end else if (!freeze) begin
      if (w_sel == C_SEL_MUL) begin
        r_mul_full <= 1'b0;
        r_mul_wait <= 4'd0;
      end else if (r_mul_full) begin
        if (r_mul_wait != C_LIMIT) begin
          r_mul_wait <= r_mul_wait + 4'd1;
        end
      end else if (mul_valid) begin
        r_mul_full   <= 1'b1;
        r_mul_rd     <= mul_rd;
        r_mul_data   <= mul_data;
        r_mul_fpusrc <= mul_fpusrc;
        r_mul_wait   <= 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_div_full   <= 1'b0;
      r_div_rd     <= 5'd0;
      r_div_data   <= 32'd0;
      r_div_fpusrc <= 1'b0;
      r_div_wait   <= 4'd0;
    end else if (!freeze) begin
      if (w_sel == C_SEL_DIV) begin
        r_div_full <= 1'b0;
        r_div_wait <= 4'd0;
      end else if (r_div_full) begin
        if (r_div_wait != C_LIMIT) begin
          r_div_wait <= r_div_wait + 4'd1;
        end
      end else if (div_valid) begin
        r_div_full   <= 1'b1;
        r_div_rd     <= div_rd;
        r_div_data   <= div_data;
        r_div_fpusrc <= div_fpusrc;
        r_div_wait   <= 4'd0;
      end
    end
  end

  // Write-port fields only move on a real write so they stay stable
  // after wb_valid drops.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
      wb_fpusrc <= 1'b0;
    end else if (!freeze) begin
      wb_valid <= w_wr_en;
      if (w_wr_en) begin
        wb_rd     <= w_gnt_rd;
        wb_data   <= w_gnt_data;
        wb_fpusrc <= w_gnt_fpusrc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter. Expected writes are
//               queued as stimulus is applied and compared in order when the
//               write port fires; scenario tasks check timing-specific
//               signals inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  logic        clk;
  logic        Rst;
  logic        freeze;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_fpusrc;
  logic        mul_valid;
  logic        mul_ready;
  logic [4:0]  mul_rd;
  logic [31:0] mul_data;
  logic        mul_fpusrc;
  logic        div_valid;
  logic        div_ready;
  logic [4:0]  div_rd;
  logic [31:0] div_data;
  logic        div_fpusrc;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_fpusrc;
  logic        pipe_stall;

  int checks = 0;
  int errors = 0;

  // Expected write: {fpusrc, rd, data}
  logic [37:0] exp_q[$];
  logic        upd_edge = 1'b0;

  wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .Rst(Rst), .freeze(freeze),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_fpusrc(pipe_fpusrc),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_rd(mul_rd),
    .mul_data(mul_data), .mul_fpusrc(mul_fpusrc),
    .div_valid(div_valid), .div_ready(div_ready), .div_rd(div_rd),
    .div_data(div_data), .div_fpusrc(div_fpusrc),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_fpusrc(wb_fpusrc), .pipe_stall(pipe_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remember whether the edge just taken was allowed to update the DUT.
  always @(posedge clk) upd_edge = Rst && !freeze;

  // Scoreboard: every fresh write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (upd_edge && wb_valid) begin
      logic [37:0] exp_w;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got rd=%0d data=%h fp=%0d, required no write",
                 wb_rd, wb_data, wb_fpusrc);
      end else begin
        exp_w = exp_q.pop_front();
        if ({wb_fpusrc, wb_rd, wb_data} !== exp_w) begin
          errors++;
          $display("FAIL sb_write: got fp=%0d rd=%0d data=%h, required fp=%0d rd=%0d data=%h",
                   wb_fpusrc, wb_rd, wb_data, exp_w[37], exp_w[36:32], exp_w[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; freeze = 1'b0;
    pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1; pipe_fpusrc = 1'b0;
    mul_valid = 1'b0; mul_rd = 5'd0; mul_data = 32'd0; mul_fpusrc = 1'b0;
    div_valid = 1'b0; div_rd = 5'd0; div_data = 32'd0; div_fpusrc = 1'b0;
    tick(); tick();
    checks++;
    if ({wb_valid, wb_rd, wb_data, wb_fpusrc} !== 39'd0) begin
      errors++;
      $display("FAIL reset_wb: got v=%0d rd=%0d data=%h fp=%0d, required all 0",
               wb_valid, wb_rd, wb_data, wb_fpusrc);
    end
    checks++;
    if ({mul_ready, div_ready, pipe_stall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: got mr=%0d dr=%0d ps=%0d, required 0 0 0",
               mul_ready, div_ready, pipe_stall);
    end
    pipe_valid = 1'b0;
    Rst = 1'b1;
    #1;
    checks++;
    if ({mul_ready, div_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_ready: got mr=%0d dr=%0d, required 1 1", mul_ready, div_ready);
    end
  endtask

  task automatic test_pipe_only();
    tick();
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF; pipe_fpusrc = 1'b0;
    exp_q.push_back({1'b0, 5'd5, 32'hDEADBEEF});
    #1;
    checks++;
    if (pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL pipe_only_stall: got %0d, required 0", pipe_stall);
    end
    tick();
    pipe_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL pipe_only_latency: wb_valid got %0d, required 1", wb_valid);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_data !== 32'hDEADBEEF || wb_rd !== 5'd5) begin
      errors++;
      $display("FAIL pipe_only_hold: got v=%0d rd=%0d data=%h, required v=0 rd=5 data=deadbeef",
               wb_valid, wb_rd, wb_data);
    end
  endtask

  task automatic test_contention();
    tick();
    mul_valid = 1'b1; mul_rd = 5'd3; mul_data = 32'h0000_0033; mul_fpusrc = 1'b0;
    #1;
    checks++;
    if (mul_ready !== 1'b1) begin
      errors++;
      $display("FAIL cont_mul_ready: got %0d, required 1", mul_ready);
    end
    // Four pipe grants while the buffered mul result ages 0..3.
    for (int i = 0; i < 4; i++) begin
      tick();
      mul_valid = 1'b0;
      pipe_valid = 1'b1; pipe_rd = 5'd7; pipe_fpusrc = 1'b0;
      pipe_data = 32'h100 + 32'(i);
      exp_q.push_back({1'b0, 5'd7, 32'h100 + 32'(i)});
      #1;
      checks++;
      if (pipe_stall !== 1'b0 || mul_ready !== 1'b0) begin
        errors++;
        $display("FAIL cont_pipe_grant%0d: got ps=%0d mr=%0d, required 0 0", i, pipe_stall, mul_ready);
      end
    end
    // Starvation limit reached: mul forced, pipe held.
    tick();
    pipe_data = 32'h104;
    exp_q.push_back({1'b0, 5'd3, 32'h0000_0033});
    #1;
    checks++;
    if (pipe_stall !== 1'b1) begin
      errors++;
      $display("FAIL cont_forced_stall: got %0d, required 1", pipe_stall);
    end
    tick();
    exp_q.push_back({1'b0, 5'd7, 32'h104});
    #1;
    checks++;
    if (wb_rd !== 5'd3 || pipe_stall !== 1'b0 || mul_ready !== 1'b1) begin
      errors++;
      $display("FAIL cont_forced_wb: got rd=%0d ps=%0d mr=%0d, required 3 0 1",
               wb_rd, pipe_stall, mul_ready);
    end
    tick();
    pipe_valid = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    tick();
    mul_valid = 1'b1; mul_rd = 5'd10; mul_data = 32'hAAAA_0010; mul_fpusrc = 1'b0;
    div_valid = 1'b1; div_rd = 5'd11; div_data = 32'hBBBB_0011; div_fpusrc = 1'b1;
    exp_q.push_back({1'b0, 5'd10, 32'hAAAA_0010});
    exp_q.push_back({1'b1, 5'd11, 32'hBBBB_0011});
    tick();
    mul_valid = 1'b0; div_valid = 1'b0;
    checks++;
    if ({mul_ready, div_ready} !== 2'b00) begin
      errors++;
      $display("FAIL sim_both_full: got mr=%0d dr=%0d, required 0 0", mul_ready, div_ready);
    end
    tick();
    checks++;
    if ({mul_ready, div_ready} !== 2'b10 || wb_rd !== 5'd10) begin
      errors++;
      $display("FAIL sim_mul_first: got mr=%0d dr=%0d rd=%0d, required 1 0 10",
               mul_ready, div_ready, wb_rd);
    end
    tick();
    checks++;
    if (div_ready !== 1'b1 || wb_fpusrc !== 1'b1 || wb_rd !== 5'd11) begin
      errors++;
      $display("FAIL sim_div_next: got dr=%0d fp=%0d rd=%0d, required 1 1 11",
               div_ready, wb_fpusrc, wb_rd);
    end
    tick();
  endtask

  task automatic test_freeze();
    tick();
    mul_valid = 1'b1; mul_rd = 5'd12; mul_data = 32'h0000_C0C0; mul_fpusrc = 1'b0;
    pipe_valid = 1'b1; pipe_rd = 5'd8; pipe_data = 32'h200; pipe_fpusrc = 1'b0;
    exp_q.push_back({1'b0, 5'd8, 32'h200});
    tick();
    mul_valid = 1'b0;
    pipe_data = 32'h201;
    exp_q.push_back({1'b0, 5'd8, 32'h201});
    tick();
    pipe_data = 32'h202;
    exp_q.push_back({1'b0, 5'd8, 32'h202});
    tick();
    // mul buffer has aged 2 cycles; freeze must preserve that.
    freeze = 1'b1;
    pipe_data = 32'h203;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h202 || mul_ready !== 1'b0 || pipe_stall !== 1'b0) begin
        errors++;
        $display("FAIL freeze_hold%0d: got v=%0d data=%h mr=%0d ps=%0d, required 1 202 0 0",
                 j, wb_valid, wb_data, mul_ready, pipe_stall);
      end
      tick();
    end
    freeze = 1'b0;
    exp_q.push_back({1'b0, 5'd8, 32'h203});
    #1;
    checks++;
    if (pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL freeze_wait2: stall got %0d, required 0", pipe_stall);
    end
    tick();
    pipe_data = 32'h204;
    exp_q.push_back({1'b0, 5'd8, 32'h204});
    #1;
    checks++;
    if (pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL freeze_wait3: stall got %0d, required 0", pipe_stall);
    end
    tick();
    pipe_data = 32'h205;
    exp_q.push_back({1'b0, 5'd12, 32'h0000_C0C0});
    #1;
    checks++;
    if (pipe_stall !== 1'b1) begin
      errors++;
      $display("FAIL freeze_resume_force: stall got %0d, required 1", pipe_stall);
    end
    tick();
    exp_q.push_back({1'b0, 5'd8, 32'h205});
    tick();
    pipe_valid = 1'b0;
    tick();
  endtask

  task automatic test_x0();
    tick();
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h55; pipe_fpusrc = 1'b0;
    tick();
    pipe_fpusrc = 1'b1; pipe_data = 32'h66;
    exp_q.push_back({1'b1, 5'd0, 32'h66});
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL x0_dropped: wb_valid got %0d, required 0", wb_valid);
    end
    tick();
    pipe_valid = 1'b0; pipe_fpusrc = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_fpusrc !== 1'b1) begin
      errors++;
      $display("FAIL f0_written: got v=%0d fp=%0d, required 1 1", wb_valid, wb_fpusrc);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h300; pipe_fpusrc = 1'b0;
    mul_valid = 1'b1; mul_rd = 5'd13; mul_data = 32'h13;
    div_valid = 1'b1; div_rd = 5'd14; div_data = 32'h14; div_fpusrc = 1'b0;
    exp_q.push_back({1'b0, 5'd9, 32'h300});
    tick();
    mul_valid = 1'b0; div_valid = 1'b0;
    pipe_data = 32'h301;
    checks++;
    if ({mul_ready, div_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_full: got mr=%0d dr=%0d, required 0 0", mul_ready, div_ready);
    end
    #5;
    Rst = 1'b0;
    #1;
    checks++;
    if ({wb_valid, wb_rd, wb_data, wb_fpusrc, mul_ready, div_ready, pipe_stall} !== 42'd0) begin
      errors++;
      $display("FAIL rmid_async: got v=%0d rd=%0d data=%h mr=%0d dr=%0d ps=%0d, required all 0",
               wb_valid, wb_rd, wb_data, mul_ready, div_ready, pipe_stall);
    end
    tick();
    pipe_valid = 1'b0;
    Rst = 1'b1;
    #1;
    checks++;
    if ({mul_ready, div_ready} !== 2'b11) begin
      errors++;
      $display("FAIL rmid_release: got mr=%0d dr=%0d, required 1 1", mul_ready, div_ready);
    end
    tick(); tick();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_discard: wb_valid got %0d, required 0", wb_valid);
    end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_contention();
    test_simultaneous();
    test_freeze();
    test_x0();
    test_reset_mid();
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d writes outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
